raster_scan_sequencer: RTL and testbench

- Controller that sequences a two-level nested row/column count over a 2D feature map, such as the 28x28 MNIST input or a pooled map.
- Emits one coordinate plus flat memory address per beat over a valid/ready stream.
- Sits between the layer control FSM and the buffer-read/MAC datapath, replacing hand-wired chains of free-running counters.

---
 rtl/raster_scan_sequencer.sv | 179 +++++++++++++++++
 tb/tb_raster_scan_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : raster_scan_sequencer
// Purpose  : Walks a 2D feature map in raster order (columns inside rows).
//            It emits one (col, row, flat address) beat per transfer over a
//            valid/ready stream. The scan geometry is captured at start, so
//            the caller may change its config inputs while a scan is running.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   begin a scan (honoured only when idle)
//   abort_i      in   terminate a running scan (wins over a transfer)
//   last_col_i   in   index of the last column (width-1)
//   last_row_i   in   index of the last row (height-1)
//   base_addr_i  in   address of element (0,0)
//   row_pitch_i  in   address step between consecutive row starts
//   ready_i      in   downstream accepts the current beat
//   valid_o      out  beat valid
//   col_o/row_o  out  coordinate of the current beat
//   addr_o       out  flat address of the current beat
//   eol_o        out  current beat is the last column of its row
//   last_o       out  current beat is the final beat of the scan
//   busy_o       out  scan in progress
//   done_o       out  one-cycle pulse after the final beat transfers
// ============================================================================
module raster_scan_sequencer #(
    parameter int unsigned COL_BITS  = 5,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [COL_BITS-1:0]  last_col_i,
    input  logic [ROW_BITS-1:0]  last_row_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    input  logic [ADDR_BITS-1:0] row_pitch_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [COL_BITS-1:0]  col_o,
    output logic [ROW_BITS-1:0]  row_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 eol_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;

    // Geometry captured at start
    logic [COL_BITS-1:0]   r_last_col;
    logic [ROW_BITS-1:0]   r_last_row;
    logic [ADDR_BITS-1:0]  r_pitch;
    logic [ADDR_BITS-1:0]  r_row_base;

    // Registered beat payload and status
    logic [COL_BITS-1:0]   r_col;
    logic [ROW_BITS-1:0]   r_row;
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_valid;
    logic                  r_eol;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_xfer;
    logic                  w_col_end;
    logic                  w_row_end;
    logic [COL_BITS-1:0]   w_col_inc;
    logic [ROW_BITS-1:0]   w_row_inc;
    logic [ADDR_BITS-1:0]  w_addr_inc;
    logic [ADDR_BITS-1:0]  w_row_base_nxt;

    assign w_xfer         = r_valid & ready_i;
    assign w_col_end      = (r_col == r_last_col);
    assign w_row_end      = (r_row == r_last_row);
    assign w_col_inc      = r_col + 1'b1;
    assign w_row_inc      = r_row + 1'b1;
    assign w_addr_inc     = r_addr + 1'b1;
    // Address arithmetic wraps naturally at the register width.
    assign w_row_base_nxt = r_row_base + r_pitch;

    // eol/last are registered alongside the coordinate they describe. Each
    // one is computed from the coordinate being loaded, so it never lags the
    // payload by a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_last_col <= '0;
            r_last_row <= '0;
            r_pitch    <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_eol      <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_last_col <= last_col_i;
                        r_last_row <= last_row_i;
                        r_pitch    <= row_pitch_i;
                        r_row_base <= base_addr_i;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_addr     <= base_addr_i;
                        r_eol      <= (last_col_i == '0);
                        r_last     <= (last_col_i == '0) && (last_row_i == '0);
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        if (!w_col_end) begin
                            r_col  <= w_col_inc;
                            r_addr <= w_addr_inc;
                            r_eol  <= (w_col_inc == r_last_col);
                            r_last <= (w_col_inc == r_last_col) && w_row_end;
                        end else if (!w_row_end) begin
                            r_col      <= '0;
                            r_row      <= w_row_inc;
                            r_row_base <= w_row_base_nxt;
                            r_addr     <= w_row_base_nxt;
                            r_eol      <= (r_last_col == '0);
                            r_last     <= (r_last_col == '0) && (w_row_inc == r_last_row);
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start_i is deliberately ignored here.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign col_o   = r_col;
    assign row_o   = r_row;
    assign addr_o  = r_addr;
    assign eol_o   = r_eol;
    assign last_o  = r_last;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_raster_scan_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_raster_scan_sequencer
// Purpose  : Self-checking bench for raster_scan_sequencer. The expected beat
//            list is computed with plain nested-loop arithmetic, and randomized
//            backpressure is applied against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_scan_sequencer;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       start_i     = 1'b0;
    logic       abort_i     = 1'b0;
    logic       ready_i     = 1'b0;
    logic [4:0] last_col_i  = '0;
    logic [4:0] last_row_i  = '0;
    logic [9:0] base_addr_i = '0;
    logic [9:0] row_pitch_i = '0;
    logic       valid_o;
    logic [4:0] col_o;
    logic [4:0] row_o;
    logic [9:0] addr_o;
    logic       eol_o;
    logic       last_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] col;
        logic [4:0] row;
        logic [9:0] addr;
        logic       eol;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk_i = ~clk_i;

    raster_scan_sequencer #(
        .COL_BITS  (5),
        .ROW_BITS  (5),
        .ADDR_BITS (10)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .last_col_i  (last_col_i),
        .last_row_i  (last_row_i),
        .base_addr_i (base_addr_i),
        .row_pitch_i (row_pitch_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .addr_o      (addr_o),
        .eol_o       (eol_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    function automatic beat_t observed();
        beat_t b;
        b.col  = col_o;
        b.row  = row_o;
        b.addr = addr_o;
        b.eol  = eol_o;
        b.last = last_o;
        return b;
    endfunction

    // Reference: the raster as a flat list, address = base + r*pitch + c mod 1024.
    task automatic build_expected(input int lc, input int lr, input int base, input int pitch);
        beat_t b;
        exp_q.delete();
        for (int r = 0; r <= lr; r++) begin
            for (int c = 0; c <= lc; c++) begin
                b.col  = 5'(c);
                b.row  = 5'(r);
                b.addr = 10'((base + r * pitch + c) & 1023);
                b.eol  = (c == lc);
                b.last = (c == lc) && (r == lr);
                exp_q.push_back(b);
            end
        end
    endtask

    // Runs one scan from IDLE. abort_beat / restart_beat are counts of
    // completed transfers at which to abort or to pulse a (to-be-ignored)
    // start; -1 disables them.
    task automatic run_scan(input int lc, input int lr, input int base, input int pitch,
                            input bit rand_ready, input int abort_beat,
                            input int restart_beat, input string name);
        beat_t exp_b;
        beat_t held;
        bit    stalled;
        bit    aborted;
        bit    restarted;
        int    xfers;
        int    cyc;
        int    done_seen;
        build_expected(lc, lr, base, pitch);
        stalled   = 1'b0;
        aborted   = 1'b0;
        restarted = 1'b0;
        xfers     = 0;
        cyc       = 0;
        done_seen = 0;
        held      = '0;

        @(negedge clk_i);
        last_col_i  = 5'(lc);
        last_row_i  = 5'(lr);
        base_addr_i = 10'(base);
        row_pitch_i = 10'(pitch);
        start_i     = 1'b1;
        ready_i     = 1'b0;
        @(negedge clk_i);
        start_i     = 1'b0;
        // Scramble the config: the running scan must use the latched copy.
        last_col_i  = 5'($urandom);
        last_row_i  = 5'($urandom);
        base_addr_i = 10'($urandom);
        row_pitch_i = 10'($urandom);

        while (exp_q.size() > 0 && !aborted && cyc < 400) begin
            checks++;
            if (valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s status at xfer %0d: valid=%b busy=%b done=%b, want 1 1 0",
                         name, xfers, valid_o, busy_o, done_o);
                break;
            end
            if (stalled) begin
                checks++;
                if (observed() !== held) begin
                    errors++;
                    $display("FAIL %s stall stability at xfer %0d: got %h, want %h",
                             name, xfers, observed(), held);
                end
            end
            start_i = 1'b0;
            if (restart_beat == xfers && !restarted) begin
                restarted   = 1'b1;
                start_i     = 1'b1;
                last_col_i  = 5'd7;
                last_row_i  = 5'd7;
                base_addr_i = 10'h2A0;
                row_pitch_i = 10'h040;
            end
            if (abort_beat == xfers) begin
                abort_i = 1'b1;
                ready_i = 1'b1;
                aborted = 1'b1;
            end else begin
                ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ready_i) begin
                    exp_b = exp_q.pop_front();
                    checks++;
                    if (observed() !== exp_b) begin
                        errors++;
                        $display("FAIL %s beat %0d: got col=%0d row=%0d addr=%h eol=%b last=%b, want col=%0d row=%0d addr=%h eol=%b last=%b",
                                 name, xfers, col_o, row_o, addr_o, eol_o, last_o,
                                 exp_b.col, exp_b.row, exp_b.addr, exp_b.eol, exp_b.last);
                    end
                    xfers++;
                end
            end
            stalled = !ready_i;
            held    = observed();
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;

        if (exp_q.size() > 0 && !aborted) begin
            checks++;
            errors++;
            $display("FAIL %s incomplete: %0d beats left after %0d cycles", name, exp_q.size(), cyc);
        end else if (aborted) begin
            abort_i = 1'b0;
            ready_i = 1'b0;
            checks++;
            if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s after abort: valid=%b busy=%b done=%b, want 0 0 0",
                         name, valid_o, busy_o, done_o);
            end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk_i);
                if (done_o === 1'b1) done_seen++;
            end
            checks++;
            if (done_seen != 0) begin
                errors++;
                $display("FAIL %s done after abort: got %0d pulses, want 0", name, done_seen);
            end
        end else begin
            checks++;
            if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
                errors++;
                $display("FAIL %s end of scan: valid=%b busy=%b done=%b, want 0 0 1",
                         name, valid_o, busy_o, done_o);
            end
            // A start during the done cycle must be ignored.
            start_i = 1'b1;
            ready_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            checks++;
            if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s after done: valid=%b busy=%b done=%b, want 0 0 0",
                         name, valid_o, busy_o, done_o);
            end
        end
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            col_o !== 5'd0 || row_o !== 5'd0 || addr_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b busy=%b done=%b col=%0d row=%0d addr=%h, want all 0",
                     valid_o, busy_o, done_o, col_o, row_o, addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Start a scan and let it run a few beats, then reset mid-cycle.
        last_col_i  = 5'd3;
        last_row_i  = 5'd2;
        base_addr_i = 10'h155;
        row_pitch_i = 10'h008;
        start_i     = 1'b1;
        ready_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            col_o !== 5'd0 || row_o !== 5'd0 || addr_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_run: valid=%b busy=%b done=%b col=%0d row=%0d addr=%h, want all 0",
                     valid_o, busy_o, done_o, col_o, row_o, addr_o);
        end
        ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
                col_o !== 5'd0 || row_o !== 5'd0 || addr_o !== 10'd0 ||
                eol_o !== 1'b0 || last_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle_hold: %0d cycles with nonzero outputs, want 0", bad);
        end
    endtask

    task automatic test_full_raster();
        run_scan(3, 2, 'h010, 'h008, 1'b0, -1, -1, "full_raster");
    endtask

    task automatic test_backpressure();
        run_scan(3, 2, 'h010, 'h008, 1'b1, -1, -1, "backpressure");
    endtask

    task automatic test_degenerate_wrap();
        run_scan(0, 0, 'h3FF, int'($urandom_range(0, 1023)), 1'b1, -1, -1, "single_beat");
        run_scan(1, 0, 'h3FF, int'($urandom_range(0, 1023)), 1'b1, -1, -1, "addr_wrap");
        run_scan(2, 3, 'h3F0, 'h3FC, 1'b0, -1, -1, "pitch_wrap");
    endtask

    task automatic test_abort_restart();
        run_scan(3, 2, 'h010, 'h008, 1'b0, 6, 5, "abort");
        run_scan(3, 2, 'h010, 'h008, 1'b1, -1, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     1'(i & 1), -1, -1, "random_scan");
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_raster();
        test_backpressure();
        test_degenerate_wrap();
        test_abort_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
